// File: rtl/cpu_clk_seq.sv
// Clock/reset sequencer for the 6502 core: divided CPU clock, power-on reset
// sequence, free-run / burst / single-step modes and a completed-cycle counter.
module cpu_clk_seq #(
    parameter int DIV_W   = 24,
    parameter int CNT_W   = 32,
    parameter int START   = 100,
    parameter int RST_CYC = 2
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             go,
    input  logic             step,
    input  logic [CNT_W-1:0] burst_len,
    output logic             cpu_clk,
    output logic             cpu_res,
    output logic             cpu_clk_rise,
    output logic             cpu_clk_fall,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cyc_count
);

    localparam logic [31:0] HOLD_LAST = (START > 0) ? 32'(START - 1) : 32'd0;
    localparam logic [31:0] RST_LAST  = (RST_CYC > 0) ? 32'(RST_CYC - 1) : 32'd0;

    typedef enum logic [2:0] {HOLD, RST_CLK, IDLE, RUN, BURST, STEP} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] ph_cnt, ph_cnt_n, div_q, div_q_n, div_eff;
    logic [31:0]      hold_cnt, hold_cnt_n, rst_cnt, rst_cnt_n;
    logic [CNT_W-1:0] remaining, remaining_n, cyc_n;
    logic             clk_n, res_n, rise_n, fall_n, done_n;
    logic             running, phase_end, completion;

    always_ff @(posedge CLK) begin
        if (!R) begin
            state        <= HOLD;
            ph_cnt       <= '0;
            div_q        <= '0;
            hold_cnt     <= '0;
            rst_cnt      <= '0;
            remaining    <= '0;
            cyc_count    <= '0;
            cpu_clk      <= 1'b0;
            cpu_res      <= 1'b1;
            cpu_clk_rise <= 1'b0;
            cpu_clk_fall <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            ph_cnt       <= ph_cnt_n;
            div_q        <= div_q_n;
            hold_cnt     <= hold_cnt_n;
            rst_cnt      <= rst_cnt_n;
            remaining    <= remaining_n;
            cyc_count    <= cyc_n;
            cpu_clk      <= clk_n;
            cpu_res      <= res_n;
            cpu_clk_rise <= rise_n;
            cpu_clk_fall <= fall_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        ph_cnt_n    = ph_cnt;
        div_q_n     = div_q;
        hold_cnt_n  = hold_cnt;
        rst_cnt_n   = rst_cnt;
        remaining_n = remaining;
        cyc_n       = cyc_count;
        clk_n       = cpu_clk;
        res_n       = cpu_res;
        rise_n      = 1'b0;
        fall_n      = 1'b0;
        done_n      = 1'b0;

        running    = (state == RST_CLK) || (state == RUN) || (state == BURST) || (state == STEP);
        // div is only looked at on the first CLK of a phase; later CLKs use the held copy
        div_eff    = (ph_cnt == '0) ? div : div_q;
        phase_end  = running && (ph_cnt == div_eff);
        completion = phase_end && cpu_clk;

        if (running) begin
            div_q_n = div_eff;
            if (phase_end) begin
                ph_cnt_n = '0;
                clk_n    = ~cpu_clk;
                rise_n   = ~cpu_clk;
                fall_n   = cpu_clk;
            end else begin
                ph_cnt_n = ph_cnt + DIV_W'(1);
            end
        end

        if (completion && (state != RST_CLK))
            cyc_n = cyc_count + CNT_W'(1);

        unique case (state)
            HOLD: begin
                hold_cnt_n = hold_cnt + 32'd1;
                if (hold_cnt >= HOLD_LAST) begin
                    ph_cnt_n  = '0;
                    rst_cnt_n = '0;
                    if (RST_CYC == 0) begin
                        res_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = RST_CLK;
                    end
                end
            end
            RST_CLK: begin
                if (completion) begin
                    if (rst_cnt == RST_LAST) begin
                        res_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        rst_cnt_n = rst_cnt + 32'd1;
                    end
                end
            end
            IDLE: begin
                clk_n    = 1'b0;
                ph_cnt_n = '0;
                if (run) begin
                    state_n = RUN;
                end else if (go && (burst_len != '0)) begin
                    state_n     = BURST;
                    remaining_n = burst_len;
                end else if (go) begin
                    done_n = 1'b1;
                end else if (step) begin
                    state_n     = STEP;
                    remaining_n = CNT_W'(1);
                end
            end
            RUN: begin
                if (completion && !run)
                    state_n = IDLE;
            end
            BURST, STEP: begin
                if (completion) begin
                    remaining_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = HOLD;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: doc/cpu_clk_seq.md
# cpu_clk_seq

Clock/reset sequencer that sits between the 12 MHz board clock and the 6502 core. It generates a divided CPU clock with a programmable divider and a power-on reset sequence that clocks the core while holding it in reset. It adds free-run, N-cycle burst and single-step modes, and keeps a completed-cycle counter. It replaces the fixed start/stop toggle logic in the board top level and drives the core's `CLK` and `R`.

## Interface
- `DIV_W`, 24: width of the `div` input.
- `CNT_W`, 32: width of `burst_len` and `cyc_count`.
- `START`, 100: CLK cycles spent in HOLD after reset release, with `cpu_clk` held low.
- `RST_CYC`, 2: full CPU cycles clocked with `cpu_res`=1 after HOLD.

Ports:
- `CLK`  in  1  board clock; all logic on its rising edge.
- `R`  in  1  reset; synchronous, active-low.
- `div`  in  DIV_W  phase length minus 1. Each `cpu_clk` phase lasts div+1 CLK cycles.
- `run`  in  1  level; free-run request.
- `go`  in  1  pulse; starts a burst of `burst_len` CPU cycles.
- `step`  in  1  pulse; runs exactly one CPU cycle.
- `burst_len`  in  CNT_W  burst length, latched on an accepted `go`.
- `cpu_clk`  out  1  divided CPU clock (registered).
- `cpu_res`  out  1  CPU reset, active-high (registered).
- `cpu_clk_rise`  out  1  one-CLK pulse in the cycle `cpu_clk` becomes 1.
- `cpu_clk_fall`  out  1  one-CLK pulse in the cycle `cpu_clk` becomes 0.
- `busy`  out  1  1 in every state except IDLE.
- `done`  out  1  one-CLK pulse when a burst or step finishes.
- `cyc_count`  out  CNT_W  CPU cycles completed since `cpu_res` fell.

## Operation
- **Reset values** (while `R`=0): `cpu_clk`=0, `cpu_res`=1, `cpu_clk_rise`=0, `cpu_clk_fall`=0, `done`=0, `busy`=1, `cyc_count`=0, state HOLD, phase counter 0. An `R`=0 in any state aborts the current activity at the next edge and restores these values.
- **States:** HOLD, RST_CLK, IDLE, RUN, BURST, STEP.
- **Phase engine** (active in RST_CLK, RUN, BURST, STEP):
  - `ph_cnt` counts 0..div. When `ph_cnt`==div, `cpu_clk` toggles and `ph_cnt` returns to 0.
  - `div` is sampled only when `ph_cnt`==0, so a change takes effect at the next phase. `div`=0 gives CLK/2.
  - A CPU cycle is low phase then high phase. The cycle completes at the high→low toggle.
- **HOLD:** count START edges, then go to RST_CLK with `ph_cnt`=0. If `RST_CYC`=0, instead drop `cpu_res` and go to IDLE.
- **RST_CLK:** run RST_CYC cycles. On the final completion, `cpu_res`←0 and state←IDLE. These cycles are not counted in `cyc_count`.
- **IDLE:** `cpu_clk` held 0; inputs are checked at each edge in this priority order:
  1. `run`=1 → RUN.
  2. `go`=1 with `burst_len`≠0 → BURST; remaining←`burst_len`.
  3. `go`=1 with `burst_len`=0 → `done` pulse, stay in IDLE.
  4. `step`=1 → STEP.
  - On entry to any running state, `ph_cnt`←0.
- **RUN:** at each completion, if `run`=0 go to IDLE. A CPU cycle is never truncated.
- **BURST:** remaining decrements at each completion. When it reaches 0, go to IDLE and pulse `done` in the same CLK cycle as the final `cpu_clk_fall`. `run`, `go` and `step` are ignored.
- **STEP:** identical to BURST with remaining=1.
- **Cycle counter:** `cyc_count` increments at every completion outside RST_CLK. It wraps modulo 2^CNT_W and does not saturate.

## Timing
- Transition into RUN/BURST/STEP at edge t0 gives `cpu_clk` rise at edge t0+(div+1) and fall at edge t0+2(div+1). The CPU period is 2(div+1) CLK.
- `cpu_clk_rise`/`cpu_clk_fall` are high for exactly the one CLK cycle in which `cpu_clk` shows its new value. `cyc_count` updates at the same edge as `cpu_clk_fall`.
- **Reset release:** counting the first edge that samples `R`=1 as edge 1, `cpu_res` falls at edge START+2·RST_CYC·(div+1). `busy` falls at the same edge.
- Latency from `go`/`step`/`run` sampled high in IDLE to the first `cpu_clk_rise` is div+1 edges.
- `done` fires 2·N·(div+1) edges after an accepted `go` of length N.
- Simultaneous `run`, `go` and `step` in IDLE: `run` wins and the pulses are dropped.
- Pulses arriving outside IDLE are dropped, not queued.

## Test plan
- **Reset sequence:** START=4, RST_CYC=2, div=1; release R → `cpu_res` falls at edge 12 with exactly 2 rises seen, `cyc_count`=0, `busy`=0.
- **Burst:** div=2, burst_len=5, one `go` pulse → exactly 5 rise/fall pairs with period 6 CLK; `done` pulse coincides with the 5th fall; `cyc_count`=5; `busy` drops.
- **Free-run stop mid-phase:** `run`=1, div=0, deassert `run` while `cpu_clk`=1 → current cycle completes and `cpu_clk` stays 0 afterwards; `cyc_count` equals the number of falls.
- **Step and priority:** `step` → exactly one cycle plus `done`. `go` with burst_len=0 → `done` next cycle with no edges. `run`+`go` together → RUN and no `done`.
- **Divider change:** div changed 3→0 mid-phase → current phase still lasts 4 CLK; following phases last 1 CLK.
- **Reset mid-burst and wrap:** drive `R`=0 during a burst → all outputs return to reset values next edge. With CNT_W=4, a burst_len=20 burst ends with `cyc_count`=4.
